// File: rtl/pid_pkg.sv
// Shared types and constants for the multi-axis PID block.
package pid_pkg;

    // Default widths used by pid_multi_axis when no override is given.
    localparam int DEF_NUM_AXES    = 3;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_GAIN_WIDTH  = 16;
    localparam int DEF_INTEG_WIDTH = 24;

    // Gain 1.0 is (1 << PID_FRAC_BITS).
    localparam int PID_FRAC_BITS   = 8;

    // FSM encoding; the value is visible on the state_dbg port.
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_ERR      = 3'd2,
        ST_P        = 3'd3,
        ST_I        = 3'd4,
        ST_D        = 3'd5,
        ST_SUM      = 3'd6,
        ST_COMPLETE = 3'd7
    } pid_state_t;

    // Clamp a signed value into [lo, hi]. Inputs up to 64 bits wide.
    function automatic longint sat_signed(input longint v, input longint lo, input longint hi);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/pid_sat_clamp.sv
// Combinational signed clamp from IN_WIDTH down to OUT_WIDTH bits.
// LO/HI give the clamp bounds; they must be representable in OUT_WIDTH
// and IN_WIDTH must not exceed 64.
module pid_sat_clamp
    import pid_pkg::*;
#(
    parameter int     IN_WIDTH  = 18,
    parameter int     OUT_WIDTH = 16,
    parameter longint LO        = -32768,
    parameter longint HI        = 32767
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    longint wide;

    // Sign-extend to 64 bits, clamp, then narrow (the clamped value always fits).
    always_comb begin
        wide = longint'(din);
        dout = OUT_WIDTH'(sat_signed(wide, LO, HI));
    end

endmodule

// File: rtl/pid_multi_axis.sv
// Time-multiplexed PID controller: one loop per axis, one shared multiplier.
// Each axis walks ERR -> P -> I -> D -> SUM; results are held in COMPLETE
// until the consumer raises wait_flag.
module pid_multi_axis
    import pid_pkg::*;
#(
    parameter int NUM_AXES    = DEF_NUM_AXES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH  = DEF_GAIN_WIDTH,
    parameter int FRAC_BITS   = PID_FRAC_BITS,
    parameter int INTEG_WIDTH = DEF_INTEG_WIDTH,
    parameter logic signed [INTEG_WIDTH-1:0] INTEG_LIMIT = 24'sd1000000
) (
    input  logic                           us_clk,
    input  logic                           reset,
    input  logic                           start_flag,
    input  logic                           wait_flag,
    input  logic                           clear_state,
    input  logic [GAIN_WIDTH-1:0]          kp,
    input  logic [GAIN_WIDTH-1:0]          ki,
    input  logic [GAIN_WIDTH-1:0]          kd,
    input  logic [NUM_AXES*DATA_WIDTH-1:0] target_rotation,
    input  logic [NUM_AXES*DATA_WIDTH-1:0] actual_rotation,
    output logic [NUM_AXES*DATA_WIDTH-1:0] rate_out,
    output logic                           pid_active,
    output logic                           pid_complete,
    output logic [STATE_W-1:0]             state_dbg
);

    localparam int EW  = DATA_WIDTH + 1;                          // error width
    localparam int DFW = DATA_WIDTH + 2;                          // error-difference width
    localparam int BW  = (INTEG_WIDTH > DFW) ? INTEG_WIDTH : DFW; // multiplier operand B
    localparam int PW  = GAIN_WIDTH + BW;                         // full product width
    localparam int SW  = PW + 2;                                  // P+I+D sum width
    localparam int AXW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int TOT = NUM_AXES * DATA_WIDTH;

    pid_state_t                     state_q;
    logic [AXW-1:0]                 axis_q;
    logic [TOT-1:0]                 target_q;
    logic [TOT-1:0]                 actual_q;
    logic [TOT-1:0]                 rate_q;
    logic signed [GAIN_WIDTH-1:0]   kp_q;
    logic signed [GAIN_WIDTH-1:0]   ki_q;
    logic signed [GAIN_WIDTH-1:0]   kd_q;
    logic signed [EW-1:0]           err_q;
    logic signed [PW-1:0]           p_term_q;
    logic signed [PW-1:0]           i_term_q;
    logic signed [PW-1:0]           d_term_q;
    logic signed [INTEG_WIDTH-1:0]  integ_q    [NUM_AXES];
    logic signed [EW-1:0]           prev_err_q [NUM_AXES];

    logic signed [DATA_WIDTH-1:0]   tgt_ax;
    logic signed [DATA_WIDTH-1:0]   act_ax;
    logic signed [EW-1:0]           err_calc;
    logic signed [INTEG_WIDTH:0]    integ_sum;
    logic signed [INTEG_WIDTH-1:0]  integ_new;
    logic signed [EW:0]             err_diff;
    logic signed [GAIN_WIDTH-1:0]   mul_a;
    logic signed [BW-1:0]           mul_b;
    logic signed [PW-1:0]           mul_a_ext;
    logic signed [PW-1:0]           mul_b_ext;
    logic signed [PW-1:0]           product;
    logic signed [PW-1:0]           product_sh;
    logic signed [SW-1:0]           total;
    logic signed [DATA_WIDTH-1:0]   total_sat;

    assign rate_out  = rate_q;
    assign state_dbg = state_q;

    // Per-axis datapath: error, integrator update, derivative difference, sum.
    always_comb begin
        tgt_ax    = target_q[int'(axis_q)*DATA_WIDTH +: DATA_WIDTH];
        act_ax    = actual_q[int'(axis_q)*DATA_WIDTH +: DATA_WIDTH];
        err_calc  = EW'(tgt_ax) - EW'(act_ax);
        integ_sum = (INTEG_WIDTH+1)'(integ_q[axis_q]) + (INTEG_WIDTH+1)'(err_q);
        err_diff  = (EW+1)'(err_q) - (EW+1)'(prev_err_q[axis_q]);
        total     = SW'(p_term_q) + SW'(i_term_q) + SW'(d_term_q);
    end

    // Shared multiplier: operand selection follows the P/I/D state.
    always_comb begin
        mul_a = kp_q;
        mul_b = BW'(err_q);
        case (state_q)
            ST_I: begin
                mul_a = ki_q;
                mul_b = BW'(integ_new);
            end
            ST_D: begin
                mul_a = kd_q;
                mul_b = BW'(err_diff);
            end
            default: ;
        endcase
        mul_a_ext  = PW'(mul_a);
        mul_b_ext  = PW'(mul_b);
        product    = mul_a_ext * mul_b_ext;
        product_sh = product >>> FRAC_BITS;
    end

    pid_sat_clamp #(
        .IN_WIDTH  (INTEG_WIDTH + 1),
        .OUT_WIDTH (INTEG_WIDTH),
        .LO        (-longint'(INTEG_LIMIT)),
        .HI        (longint'(INTEG_LIMIT))
    ) u_integ_clamp (
        .din  (integ_sum),
        .dout (integ_new)
    );

    pid_sat_clamp #(
        .IN_WIDTH  (SW),
        .OUT_WIDTH (DATA_WIDTH),
        .LO        (-(longint'(1) <<< (DATA_WIDTH-1))),
        .HI        ((longint'(1) <<< (DATA_WIDTH-1)) - 1)
    ) u_out_sat (
        .din  (total),
        .dout (total_sat)
    );

    // Control FSM with registered status outputs and per-axis state updates.
    always_ff @(posedge us_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            axis_q       <= '0;
            pid_active   <= 1'b0;
            pid_complete <= 1'b0;
            rate_q       <= '0;
            target_q     <= '0;
            actual_q     <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            kd_q         <= '0;
            err_q        <= '0;
            p_term_q     <= '0;
            i_term_q     <= '0;
            d_term_q     <= '0;
            for (int a = 0; a < NUM_AXES; a++) begin
                integ_q[a]    <= '0;
                prev_err_q[a] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pid_active   <= 1'b0;
                    pid_complete <= 1'b1;
                    if (clear_state) begin
                        for (int a = 0; a < NUM_AXES; a++) begin
                            integ_q[a]    <= '0;
                            prev_err_q[a] <= '0;
                        end
                    end else if (start_flag) begin
                        state_q      <= ST_LATCH;
                        pid_active   <= 1'b1;
                        pid_complete <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    target_q <= target_rotation;
                    actual_q <= actual_rotation;
                    kp_q     <= kp;
                    ki_q     <= ki;
                    kd_q     <= kd;
                    axis_q   <= '0;
                    state_q  <= ST_ERR;
                end
                ST_ERR: begin
                    err_q   <= err_calc;
                    state_q <= ST_P;
                end
                ST_P: begin
                    p_term_q <= product_sh;
                    state_q  <= ST_I;
                end
                ST_I: begin
                    integ_q[axis_q] <= integ_new;
                    i_term_q        <= product_sh;
                    state_q         <= ST_D;
                end
                ST_D: begin
                    d_term_q <= product_sh;
                    state_q  <= ST_SUM;
                end
                ST_SUM: begin
                    rate_q[int'(axis_q)*DATA_WIDTH +: DATA_WIDTH] <= total_sat;
                    prev_err_q[axis_q] <= err_q;
                    if (axis_q == AXW'(NUM_AXES - 1)) begin
                        state_q      <= ST_COMPLETE;
                        pid_complete <= 1'b1;
                    end else begin
                        axis_q  <= axis_q + 1'b1;
                        state_q <= ST_ERR;
                    end
                end
                ST_COMPLETE: begin
                    if (wait_flag) begin
                        state_q    <= ST_IDLE;
                        pid_active <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_multi_axis.sv
// Directed bench for pid_multi_axis (3 axes, 16-bit data, Q8 gains, integrator limit 1000).
module tb_pid_multi_axis;

    logic        us_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_flag = 1'b0;
    logic        wait_flag = 1'b0;
    logic        clear_state = 1'b0;
    logic [15:0] kp = '0;
    logic [15:0] ki = '0;
    logic [15:0] kd = '0;
    logic [47:0] target_rotation = '0;
    logic [47:0] actual_rotation = '0;
    logic [47:0] rate_out;
    logic        pid_active;
    logic        pid_complete;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COMPLETE = 3'd7;

    pid_multi_axis #(
        .NUM_AXES    (3),
        .DATA_WIDTH  (16),
        .GAIN_WIDTH  (16),
        .FRAC_BITS   (8),
        .INTEG_WIDTH (24),
        .INTEG_LIMIT (24'sd1000)
    ) dut (
        .us_clk          (us_clk),
        .reset           (reset),
        .start_flag      (start_flag),
        .wait_flag       (wait_flag),
        .clear_state     (clear_state),
        .kp              (kp),
        .ki              (ki),
        .kd              (kd),
        .target_rotation (target_rotation),
        .actual_rotation (actual_rotation),
        .rate_out        (rate_out),
        .pid_active      (pid_active),
        .pid_complete    (pid_complete),
        .state_dbg       (state_dbg)
    );

    // Clock
    always #5 us_clk = ~us_clk;

    function automatic logic [15:0] axis_out(input int a);
        return rate_out[a*16 +: 16];
    endfunction

    // Driver: hold reset for two edges, leave all inputs idle.
    task automatic do_reset();
        start_flag = 1'b0; wait_flag = 1'b0; clear_state = 1'b0;
        kp = '0; ki = '0; kd = '0;
        target_rotation = '0; actual_rotation = '0;
        reset = 1'b1;
        repeat (2) @(posedge us_clk);
        #1;
        reset = 1'b0;
        @(posedge us_clk);
        #1;
    endtask

    // Driver: start_flag is sampled on the next edge (edge 0 of the pass).
    task automatic start_pass();
        start_flag = 1'b1;
        @(posedge us_clk);
        #1;
        start_flag = 1'b0;
    endtask

    // Driver: run one pass; cycles = edges after edge 0 until pid_complete, -1 on timeout.
    task automatic run_pass(output int cycles);
        cycles = -1;
        start_pass();
        for (int n = 1; n <= 100; n++) begin
            @(posedge us_clk);
            #1;
            if (pid_complete) begin
                cycles = n;
                break;
            end
        end
    endtask

    // Driver: one-cycle wait_flag pulse.
    task automatic wait_pulse();
        wait_flag = 1'b1;
        @(posedge us_clk);
        #1;
        wait_flag = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge us_clk);
        #1;
        checks++; if (rate_out !== 48'd0) begin errors++; $display("FAIL reset_rate got %h expected 0", rate_out); end
        checks++; if (pid_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b expected 0", pid_active); end
        checks++; if (pid_complete !== 1'b0) begin errors++; $display("FAIL reset_complete got %b expected 0", pid_complete); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d expected 0", state_dbg); end
        reset = 1'b0;
        @(posedge us_clk);
        #1;
        checks++; if (pid_complete !== 1'b1) begin errors++; $display("FAIL idle_complete got %b expected 1", pid_complete); end
    endtask

    task automatic test_proportional();
        int done;
        do_reset();
        kp = 16'h0100;
        target_rotation = {16'd0, 16'd0, 16'd100};
        actual_rotation = {16'd0, 16'd0, 16'd40};
        done = -1;
        start_pass();
        checks++; if (pid_active !== 1'b1) begin errors++; $display("FAIL active_after_start got %b expected 1", pid_active); end
        for (int n = 1; n <= 100; n++) begin
            @(posedge us_clk);
            #1;
            if (n <= 16) begin
                checks++; if (pid_active !== 1'b1) begin errors++; $display("FAIL active_edge_%0d got %b expected 1", n, pid_active); end
            end
            if (pid_complete) begin
                done = n;
                break;
            end
        end
        checks++; if (done !== 16) begin errors++; $display("FAIL latency got %0d expected 16", done); end
        checks++; if (axis_out(0) !== 16'd60) begin errors++; $display("FAIL p_axis0 got %0d expected 60", axis_out(0)); end
        checks++; if (axis_out(1) !== 16'd0) begin errors++; $display("FAIL p_axis1 got %0d expected 0", axis_out(1)); end
        checks++; if (axis_out(2) !== 16'd0) begin errors++; $display("FAIL p_axis2 got %0d expected 0", axis_out(2)); end
        wait_pulse();
    endtask

    task automatic test_saturation();
        int done;
        do_reset();
        kp = 16'h0100;
        target_rotation = {16'd0, 16'd0, 16'h7FFF};
        actual_rotation = {16'd0, 16'd0, 16'h8000};
        run_pass(done);
        checks++; if (axis_out(0) !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got %h expected 7fff", axis_out(0)); end
        wait_pulse();
        target_rotation = {16'd0, 16'd0, 16'h8000};
        actual_rotation = {16'd0, 16'd0, 16'h7FFF};
        run_pass(done);
        checks++; if (axis_out(0) !== 16'h8000) begin errors++; $display("FAIL sat_neg got %h expected 8000", axis_out(0)); end
        checks++; if (axis_out(1) !== 16'd0) begin errors++; $display("FAIL sat_axis1 got %h expected 0", axis_out(1)); end
        wait_pulse();
    endtask

    task automatic test_integrator_clamp();
        int done;
        logic [15:0] exp_i [3];
        exp_i[0] = 16'd600; exp_i[1] = 16'd1000; exp_i[2] = 16'd1000;
        do_reset();
        ki = 16'h0100;
        target_rotation = {16'd0, 16'd0, 16'd600};
        for (int p = 0; p < 3; p++) begin
            run_pass(done);
            checks++; if (axis_out(0) !== exp_i[p]) begin errors++; $display("FAIL integ_pass%0d got %0d expected %0d", p, axis_out(0), exp_i[p]); end
            wait_pulse();
        end
    endtask

    task automatic test_derivative_clear();
        int done;
        do_reset();
        kd = 16'h0100;
        target_rotation = {16'd0, 16'd10, 16'd0};
        run_pass(done);
        checks++; if (axis_out(1) !== 16'd10) begin errors++; $display("FAIL d_pass1 got %0d expected 10", axis_out(1)); end
        wait_pulse();
        target_rotation = {16'd0, 16'd30, 16'd0};
        run_pass(done);
        checks++; if (axis_out(1) !== 16'd20) begin errors++; $display("FAIL d_pass2 got %0d expected 20", axis_out(1)); end
        wait_pulse();
        // clear_state together with start_flag: clear wins, no pass starts
        clear_state = 1'b1;
        start_flag = 1'b1;
        @(posedge us_clk);
        #1;
        clear_state = 1'b0;
        start_flag = 1'b0;
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL clear_blocks_start got %0d expected 0", state_dbg); end
        checks++; if (axis_out(1) !== 16'd20) begin errors++; $display("FAIL clear_hold got %0d expected 20", axis_out(1)); end
        run_pass(done);
        checks++; if (axis_out(1) !== 16'd30) begin errors++; $display("FAIL d_after_clear got %0d expected 30", axis_out(1)); end
        wait_pulse();
    endtask

    task automatic test_reset_mid_pass();
        int done;
        do_reset();
        kp = 16'h0100;
        ki = 16'h0100;
        target_rotation = {16'd0, 16'd5, 16'd60};
        start_pass();
        repeat (6) @(posedge us_clk);
        #1;
        checks++; if (axis_out(0) !== 16'd120) begin errors++; $display("FAIL midpass_axis0 got %0d expected 120", axis_out(0)); end
        reset = 1'b1;
        @(posedge us_clk);
        #1;
        checks++; if (rate_out !== 48'd0) begin errors++; $display("FAIL abort_rate got %h expected 0", rate_out); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL abort_state got %0d expected 0", state_dbg); end
        checks++; if (pid_active !== 1'b0) begin errors++; $display("FAIL abort_active got %b expected 0", pid_active); end
        checks++; if (pid_complete !== 1'b0) begin errors++; $display("FAIL abort_complete got %b expected 0", pid_complete); end
        reset = 1'b0;
        @(posedge us_clk);
        #1;
        run_pass(done);
        checks++; if (done !== 16) begin errors++; $display("FAIL abort_latency got %0d expected 16", done); end
        checks++; if (axis_out(0) !== 16'd120) begin errors++; $display("FAIL fresh_axis0 got %0d expected 120", axis_out(0)); end
        checks++; if (axis_out(1) !== 16'd10) begin errors++; $display("FAIL fresh_axis1 got %0d expected 10", axis_out(1)); end
        wait_pulse();
    endtask

    task automatic test_busy_start_ignored();
        int done;
        do_reset();
        kp = 16'h0100;
        target_rotation = {16'd0, 16'd0, 16'd60};
        done = -1;
        start_pass();
        for (int n = 1; n <= 100; n++) begin
            start_flag = (n == 3 || n == 10) ? 1'b1 : 1'b0;
            @(posedge us_clk);
            #1;
            if (pid_complete) begin
                done = n;
                break;
            end
        end
        start_flag = 1'b0;
        checks++; if (done !== 16) begin errors++; $display("FAIL busy_latency got %0d expected 16", done); end
        checks++; if (axis_out(0) !== 16'd60) begin errors++; $display("FAIL busy_axis0 got %0d expected 60", axis_out(0)); end
        target_rotation = {16'd0, 16'd0, 16'd200};
        start_pass();
        repeat (20) @(posedge us_clk);
        #1;
        checks++; if (state_dbg !== S_COMPLETE) begin errors++; $display("FAIL complete_hold got %0d expected 7", state_dbg); end
        checks++; if (axis_out(0) !== 16'd60) begin errors++; $display("FAIL complete_rate got %0d expected 60", axis_out(0)); end
        checks++; if (pid_active !== 1'b1) begin errors++; $display("FAIL complete_active got %b expected 1", pid_active); end
        wait_pulse();
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL wait_to_idle got %0d expected 0", state_dbg); end
        checks++; if (pid_active !== 1'b0) begin errors++; $display("FAIL idle_active got %b expected 0", pid_active); end
        checks++; if (pid_complete !== 1'b1) begin errors++; $display("FAIL idle_ready got %b expected 1", pid_complete); end
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_saturation();
        test_integrator_clamp();
        test_derivative_clear();
        test_reset_mid_pass();
        test_busy_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
